// File: rtl/i2s_transmitter_pkg.sv
// rtl/i2s_transmitter_pkg.sv - shared sound constants and types for the I2S transmitter
package i2s_transmitter_pkg;

  localparam int SLOTS_PER_FRAME = 32;
  localparam int SAMPLE_WIDTH    = 16;
  localparam int SLOT_W          = $clog2(SLOTS_PER_FRAME);
  localparam int FRAME_W         = 2 * SAMPLE_WIDTH;

  typedef logic [SLOT_W-1:0]              slot_t;
  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
  typedef logic [FRAME_W-1:0]             frame_t;

  // Left word occupies the upper half so it leaves the shifter first.
  function automatic frame_t frame_word(input logic mute, input sample_t left, input sample_t right);
    return mute ? '0 : {left, right};
  endfunction

endpackage

// File: rtl/i2s_transmitter_if.sv
// rtl/i2s_transmitter_if.sv - mixer-side sample inputs and I2S serial outputs
interface i2s_transmitter_if;
  import i2s_transmitter_pkg::*;

  logic    mute;
  sample_t audio_l;
  sample_t audio_r;
  logic    i2s_bck;
  logic    i2s_lrck;
  logic    i2s_data;
  logic    sample_stb;

  modport master (
    input  mute, audio_l, audio_r,
    output i2s_bck, i2s_lrck, i2s_data, sample_stb
  );

  modport slave (
    output mute, audio_l, audio_r,
    input  i2s_bck, i2s_lrck, i2s_data, sample_stb
  );

endinterface

// File: rtl/i2s_transmitter_clkgen.sv
// rtl/i2s_transmitter_clkgen.sv - BCK divider and slot counter
module i2s_transmitter_clkgen
  import i2s_transmitter_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic  clk,
  input  logic  reset_n,
  output logic  bck,
  output logic  fall,
  output slot_t slot,
  output slot_t slot_next
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic             wrap;

  assign wrap      = (div == DIV_W'(CLK_DIV - 1));
  // fall is a look-ahead: bck drops to 0 on the coming clock edge.
  assign fall      = wrap && bck;
  assign slot_next = slot + slot_t'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div  <= '0;
      bck  <= 1'b0;
      slot <= slot_t'(SLOTS_PER_FRAME - 1);
    end else begin
      div <= wrap ? '0 : div + DIV_W'(1);
      if (wrap) begin
        bck <= ~bck;
      end
      if (fall) begin
        slot <= slot_next;
      end
    end
  end

endmodule

// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - standard I2S serialiser for 16-bit stereo samples
module i2s_transmitter
  import i2s_transmitter_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input logic         clk,
  input logic         reset_n,
  i2s_transmitter_if.master bus
);

  logic   bck;
  logic   fall;
  slot_t  slot;
  slot_t  slot_next;
  logic   frame_start;
  frame_t shift;
  logic   lrck;
  logic   data;
  logic   stb;

  i2s_transmitter_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk       (clk),
    .reset_n   (reset_n),
    .bck       (bck),
    .fall      (fall),
    .slot      (slot),
    .slot_next (slot_next)
  );

  assign frame_start = fall && (slot == slot_t'(SLOTS_PER_FRAME - 1));

  // The shifter doubles as the holding register: after 31 shifts its MSB is the
  // previous right word's LSB, which is exactly the slot-0 bit of the new frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift <= '0;
      lrck  <= 1'b0;
      data  <= 1'b0;
      stb   <= 1'b0;
    end else begin
      stb <= frame_start;
      if (fall) begin
        lrck <= (slot_next >= slot_t'(SLOTS_PER_FRAME / 2));
        data <= shift[FRAME_W-1];
        if (frame_start) begin
          shift <= frame_word(bus.mute, bus.audio_l, bus.audio_r);
        end else begin
          shift <= {shift[FRAME_W-2:0], 1'b0};
        end
      end
    end
  end

  assign bus.i2s_bck    = bck;
  assign bus.i2s_lrck   = lrck;
  assign bus.i2s_data   = data;
  assign bus.sample_stb = stb;

endmodule

// File: tb/tb_i2s_transmitter.sv
// tb/tb_i2s_transmitter.sv - self-checking bench for i2s_transmitter (CLK_DIV 4 and 1)
module tb_i2s_transmitter;
  import i2s_transmitter_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  i2s_transmitter_if bus4();
  i2s_transmitter_if bus1();

  i2s_transmitter #(.CLK_DIV(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));
  i2s_transmitter #(.CLK_DIV(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    bit          mute_cap;
    bit          mute_mid;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs[NV];

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          sel      = 1'b0;
  int          cyc      = 0;
  logic [15:0] words[$];
  logic        rx[$];
  logic        prev_bck = 1'b0;

  int          m_d, m_m, m_n, m_w;
  logic [15:0] m_word;
  logic        e_bck, e_lrck, e_data, e_stb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int div_sel();
    return sel ? 1 : 4;
  endfunction

  // Reference model: cycle count since reset release, captured words in transmit order.
  always @(posedge clk) begin
    if (!reset_n) begin
      cyc = 0;
      words.delete();
      rx.delete();
    end else begin
      cyc = cyc + 1;
      m_d = div_sel();
      if (cyc >= 2*m_d && (cyc - 2*m_d) % (64*m_d) == 0) begin
        if (sel ? bus1.mute : bus4.mute) begin
          words.push_back(16'h0);
          words.push_back(16'h0);
        end else begin
          words.push_back(sel ? bus1.audio_l : bus4.audio_l);
          words.push_back(sel ? bus1.audio_r : bus4.audio_r);
        end
      end
    end
  end

  // Serial stream is one zero bit followed by every captured word MSB-first.
  always @(negedge clk) begin
    if (reset_n && cyc > 0) begin
      m_d   = div_sel();
      e_bck = ((cyc / m_d) % 2) == 1;
      e_stb = (cyc >= 2*m_d) && ((cyc - 2*m_d) % (64*m_d) == 0);
      e_lrck = 1'b0;
      e_data = 1'b0;
      if (cyc >= 2*m_d) begin
        m_m    = cyc / (2*m_d);
        m_n    = m_m - 1;
        e_lrck = (m_n % 32) >= 16;
        if (m_n > 0) begin
          m_w = (m_n - 1) / 16;
          if (m_w < words.size()) begin
            m_word = words[m_w];
            e_data = m_word[15 - ((m_n - 1) % 16)];
          end else begin
            chk("model_words", words.size(), m_w + 1);
          end
        end
      end
      chk("bck",  sel ? bus1.i2s_bck    : bus4.i2s_bck,    e_bck);
      chk("lrck", sel ? bus1.i2s_lrck   : bus4.i2s_lrck,   e_lrck);
      chk("data", sel ? bus1.i2s_data   : bus4.i2s_data,   e_data);
      chk("stb",  sel ? bus1.sample_stb : bus4.sample_stb, e_stb);
      if (!sel && cyc > 8 && bus4.i2s_bck && !prev_bck)
        rx.push_back(bus4.i2s_data);
    end
    prev_bck = bus4.i2s_bck;
  end

  task automatic wait_cyc(input int c);
    int guard = 0;
    while (cyc < c && guard < 200000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < c) begin
      $display("FAIL wait_cyc: reached %0d expected %0d", cyc, c);
      n_fail++;
      $fatal(1, "bench stalled");
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int t;
    int f;
    int last;
    logic [15:0] wl;
    logic [15:0] wr;

    vecs[0] = '{16'h8001, 16'h7FFE, 1'b0, 1'b0, 16'h8001, 16'h7FFE};
    vecs[1] = '{16'h1234, 16'h5678, 1'b1, 1'b0, 16'h0000, 16'h0000};
    vecs[2] = '{16'h1234, 16'hABCD, 1'b0, 1'b1, 16'h1234, 16'hABCD};
    vecs[3] = '{16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 16'h0000};
    vecs[4] = '{16'h0000, 16'h8000, 1'b0, 1'b1, 16'h0000, 16'h8000};

    reset_n = 1'b0;
    bus4.mute = 1'b0; bus4.audio_l = '0; bus4.audio_r = '0;
    bus1.mute = 1'b0; bus1.audio_l = '0; bus1.audio_r = '0;
    repeat (3) @(negedge clk);
    chk("rst_bck4",  bus4.i2s_bck, 0);
    chk("rst_lrck4", bus4.i2s_lrck, 0);
    chk("rst_data4", bus4.i2s_data, 0);
    chk("rst_stb4",  bus4.sample_stb, 0);
    chk("rst_bck1",  bus1.i2s_bck, 0);
    chk("rst_stb1",  bus1.sample_stb, 0);
    reset_n = 1'b1;

    // Run into slot 20 with busy inputs, then reset asynchronously mid-cycle.
    for (int c = 0; c < 170; c++) begin
      wait_cyc(c);
      bus4.audio_l = 16'($urandom);
      bus4.audio_r = 16'($urandom);
    end
    wait_cyc(170);
    chk("pre_rst_lrck", bus4.i2s_lrck, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_bck",  bus4.i2s_bck, 0);
    chk("arst_lrck", bus4.i2s_lrck, 0);
    chk("arst_data", bus4.i2s_data, 0);
    chk("arst_stb",  bus4.sample_stb, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    t = 0;
    while (!bus4.sample_stb && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("first_stb_cyc", t, 8);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus4.sample_stb && t < 600);
    chk("stb_period", t, 256);

    pulse_reset();
    last = 8 * (32*NV + 1) + 8;
    for (int c = 0; c < last; c++) begin
      wait_cyc(c);
      if (c + 1 >= 8 && (c + 1 - 8) % 256 == 0 && (c + 1 - 8) / 256 < NV) begin
        f = (c + 1 - 8) / 256;
        bus4.audio_l = vecs[f].l;
        bus4.audio_r = vecs[f].r;
        bus4.mute    = vecs[f].mute_cap;
      end else begin
        bus4.audio_l = 16'($urandom);
        bus4.audio_r = 16'($urandom);
        f = (c >= 8) ? (c - 8) / 256 : NV;
        bus4.mute = (f < NV) && vecs[f].mute_mid && ((c - 8) % 256 >= 50) && ((c - 8) % 256 <= 150);
      end
    end
    bus4.mute = 1'b0;

    if (rx.size() < 32*NV + 1) begin
      chk("rx_len", rx.size(), 32*NV + 1);
    end else begin
      for (int i = 0; i < NV; i++) begin
        for (int b = 0; b < 16; b++) begin
          wl[15-b] = rx[1 + 32*i + b];
          wr[15-b] = rx[17 + 32*i + b];
        end
        chk($sformatf("vec%0d_l", i), wl, vecs[i].exp_l);
        chk($sformatf("vec%0d_r", i), wr, vecs[i].exp_r);
      end
    end

    // CLK_DIV = 1: random samples and sporadic mute over 100+ frames.
    reset_n = 1'b0;
    sel = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 64*101 + 4; c++) begin
      wait_cyc(c);
      bus1.audio_l = 16'($urandom);
      bus1.audio_r = 16'($urandom);
      bus1.mute    = ($urandom_range(0, 7) == 0);
    end
    chk("div1_frames", words.size() >= 2*100, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_transmitter.md
I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per BCK half-period; legal range >= 1.
REQ-002 SHALL have port clk  input  1  system clock; the only clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port mute  input  1  when 1 at capture, zero samples are transmitted.
REQ-005 SHALL have port audio_l  input  16  signed left sample from the mixer stage.
REQ-006 SHALL have port audio_r  input  16  signed right sample from the mixer stage.
REQ-007 SHALL have port i2s_bck  output  1  bit clock.
REQ-008 SHALL have port i2s_lrck  output  1  word select: 0 = left, 1 = right.
REQ-009 SHALL have port i2s_data  output  1  serial data, MSB first, two's complement.
REQ-010 SHALL have port sample_stb  output  1  one-clk pulse marking sample capture.

Function
REQ-011 SHALL run a divider counting 0..CLK_DIV-1 and toggle i2s_bck in the cycle the count wraps; BCK period = 2*CLK_DIV clk.
REQ-012 SHALL keep slot counter 0..31, advanced on every BCK falling edge (i2s_bck 1->0); 31 wraps to 0.
REQ-013 SHALL drive i2s_lrck = 0 in slots 0..15 and 1 in slots 16..31.
REQ-014 SHALL drive i2s_data: slot 0 = R[0] of previous frame; slots 1..15 = L[15..1]; slot 16 = L[0]; slots 17..31 = R[15..1] (standard I2S one-BCK delay).
REQ-015 SHALL update i2s_lrck and i2s_data in the same clk cycle as the BCK falling edge; all outputs registered, stable across the BCK rising edge.
REQ-016 SHALL capture audio_l/audio_r into holding registers on the 31->0 slot transition; samples are never read at any other time.
REQ-017 SHALL capture zeros instead of audio inputs when mute = 1 in the capture cycle; mute elsewhere has no effect on the frame in progress.
REQ-018 SHALL assert sample_stb for exactly the capture cycle; one pulse per frame = 64*CLK_DIV clk.
REQ-019 SHALL transmit captured words bit-exact; no scaling, clipping or dither.
REQ-020 SHALL, with CLK_DIV = 1, toggle i2s_bck every clk cycle with no lost slots.

Reset
REQ-021 SHALL on reset_n = 0 immediately force i2s_bck = 0, i2s_lrck = 0, i2s_data = 0, sample_stb = 0, divider = 0, slot = 31, holding and shift registers = 0.
REQ-022 SHALL, after reset_n release, produce the first BCK falling edge, slot 0 and first sample_stb at clk cycle 2*CLK_DIV; slot-0 data bit = 0.
REQ-023 SHALL abandon any frame in progress when reset asserts mid-frame; no partial word resumes after release.

Structure
REQ-024 SHALL place constants SLOTS_PER_FRAME = 32 and SAMPLE_WIDTH = 16 in the shared sound package.
REQ-025 SHALL be a single module; BCK/slot generation MAY be sub-module i2s_clkgen (outputs bck, falling-edge strobe, slot).

Verification
REQ-026 SHALL check CLK_DIV = 4, audio_l = 16'h8001, audio_r = 16'h7FFE -> i2s_data slots 1..16 = 1000000000000001, slots 17..31 + next slot 0 = 0111111111111110.
REQ-027 SHALL check reset release with CLK_DIV = 4 -> first BCK fall and sample_stb at clk 8; sample_stb period 256 clk; lrck period 32 BCK.
REQ-028 SHALL check mute = 1 only in the capture cycle with audio_l = 16'h1234 -> whole frame all zeros; mute = 1 mid-frame -> current frame unchanged.
REQ-029 SHALL check audio_l changing every clk between captures -> transmitted word = value present at sample_stb cycle only.
REQ-030 SHALL check reset_n asserted at slot 20 -> outputs 0 within the same cycle; restart timing identical to REQ-027.
REQ-031 SHALL check CLK_DIV = 1 with random samples -> reconstructed L/R stream matches captured samples over 100 frames.
